// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the wait-state test memory
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH_LOG2_DEFAULT = 10;
    localparam int WORDS = 2 ** DEPTH_LOG2_DEFAULT;

    // Number of byte-offset address bits below the word index.
    function automatic int calc_lsb(input int data_w);
        return (data_w <= 8) ? 0 : $clog2(data_w / 8);
    endfunction

    function automatic int calc_words(input int depth_log2);
        return 2 ** depth_log2;
    endfunction

endpackage

// File: rtl/mem_wait_ctrl.sv
// rtl/mem_wait_ctrl.sv - request/ready handshake FSM with programmable wait counter
module mem_wait_ctrl
    import mem_pkg::*;
#(
    parameter int READ_WAIT  = 3,
    parameter int WRITE_WAIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic we,
    output logic start,
    output logic is_write,
    output logic commit,
    output logic ready,
    output logic busy
);

    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 2);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, load_val;
    logic              we_q;

    // A request is only taken in IDLE; commit marks the edge that enters RESP.
    // With zero wait states that edge is the sampling edge itself, so the
    // live we is used there instead of the captured copy.
    assign start    = reset && (state == IDLE) && req;
    assign load_val = we ? CNT_W'(WRITE_WAIT) : CNT_W'(READ_WAIT);
    assign is_write = start ? we : we_q;
    assign commit   = (start && (load_val == '0)) ||
                      (reset && (state == WAIT) && (cnt == CNT_W'(1)));

    // Next-state and counter logic.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    cnt_nx   = load_val;
                    state_nx = (load_val == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs; reset aborts any request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
            ready <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            ready <= commit;
            if (start) begin
                we_q <= we;
                busy <= 1'b1;
            end else if (state == RESP) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wait_state_mem.sv
// rtl/wait_state_mem.sv - word memory with req/ready handshake, wait states and byte enables
module wait_state_mem
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_WAIT  = 3,
    parameter int WRITE_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   byte_en,
    output logic [DATA_W-1:0]     read_data,
    output logic                  ready,
    output logic                  busy
);

    localparam int LSB     = calc_lsb(DATA_W);
    localparam int NB      = DATA_W / 8;
    localparam int WORDS_L = calc_words(DEPTH_LOG2);

    // Never reset, so preloaded contents survive a reset.
    logic [DATA_W-1:0] mem_data [0:WORDS_L-1];

    logic                  start, is_write, commit;
    logic [DEPTH_LOG2-1:0] idx_in, idx_q, eff_idx;
    logic [DATA_W-1:0]     wdata_q, eff_wdata;
    logic [NB-1:0]         be_q, eff_be;
    logic                  unused_addr_bits;

    // Bits outside the word index are ignored, so addresses alias modulo depth.
    assign idx_in           = address[LSB +: DEPTH_LOG2];
    assign unused_addr_bits = ^address;

    assign eff_idx   = start ? idx_in     : idx_q;
    assign eff_wdata = start ? write_data : wdata_q;
    assign eff_be    = start ? byte_en    : be_q;

    mem_wait_ctrl #(
        .READ_WAIT  (READ_WAIT),
        .WRITE_WAIT (WRITE_WAIT)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .start    (start),
        .is_write (is_write),
        .commit   (commit),
        .ready    (ready),
        .busy     (busy)
    );

    // Operand capture on acceptance; held stable until the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (start) begin
            idx_q   <= idx_in;
            wdata_q <= write_data;
            be_q    <= byte_en;
        end
    end

    // Byte-masked write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit && is_write) begin
            for (int b = 0; b < NB; b++) begin
                if (eff_be[b]) begin
                    mem_data[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read response register; only reads update it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data <= '0;
        end else if (commit && !is_write) begin
            read_data <= mem_data[eff_idx];
        end
    end

endmodule

// File: tb/tb_wait_state_mem.sv
// tb/tb_wait_state_mem.sv - self-checking bench for wait_state_mem
module tb_wait_state_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n, req, we, rdy, bsy;
    logic [1:0][31:0] addr, wdata, rdata;
    logic [1:0][3:0]  be;

    wait_state_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(10), .READ_WAIT(3), .WRITE_WAIT(1)
    ) dut0 (
        .clk(clk), .reset(rst_n[0]), .req(req[0]), .we(we[0]), .address(addr[0]),
        .write_data(wdata[0]), .byte_en(be[0]), .read_data(rdata[0]),
        .ready(rdy[0]), .busy(bsy[0])
    );

    wait_state_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(4), .READ_WAIT(0), .WRITE_WAIT(1)
    ) dut1 (
        .clk(clk), .reset(rst_n[1]), .req(req[1]), .we(we[1]), .address(addr[1]),
        .write_data(wdata[1]), .byte_en(be[1]), .read_data(rdata[1]),
        .ready(rdy[1]), .busy(bsy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: each accepted request completes a fixed number
    // of edges later; memory is a plain array updated at completion.
    int          rw_c [2] = '{3, 0};
    int          ww_c [2] = '{1, 1};
    int          dl_c [2] = '{10, 4};
    logic [31:0] mm [2][1024];
    bit          mk [2][1024];
    int          edge_n = 0;
    int          next_free [2];
    int          rdy_edge [2];
    bit          have [2];
    bit          op_we [2];
    int          op_idx [2];
    logic [31:0] op_wd [2];
    logic [3:0]  op_be [2];
    logic [31:0] exp_rd [2];
    bit          rd_known [2];
    int          mw;

    always begin
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                have[i]      = 1'b0;
                next_free[i] = 0;
                exp_rd[i]    = 32'h0;
                rd_known[i]  = 1'b1;
            end else begin
                if (req[i] && edge_n >= next_free[i]) begin
                    mw           = we[i] ? ww_c[i] : rw_c[i];
                    have[i]      = 1'b1;
                    rdy_edge[i]  = edge_n + mw;
                    next_free[i] = rdy_edge[i] + 2;
                    op_we[i]     = we[i];
                    op_idx[i]    = int'(addr[i] >> 2) & ((1 << dl_c[i]) - 1);
                    op_wd[i]     = wdata[i];
                    op_be[i]     = be[i];
                end
                if (have[i] && edge_n == rdy_edge[i]) begin
                    if (op_we[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (op_be[i][b]) mm[i][op_idx[i]][8*b +: 8] = op_wd[i][8*b +: 8];
                        if (op_be[i] == 4'hF) mk[i][op_idx[i]] = 1'b1;
                    end else begin
                        exp_rd[i]   = mm[i][op_idx[i]];
                        rd_known[i] = mk[i][op_idx[i]];
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc%0d_ready%0d", edge_n, i), {31'h0, rdy[i]},
                {31'h0, rst_n[i] && have[i] && edge_n == rdy_edge[i]});
            chk($sformatf("cyc%0d_busy%0d", edge_n, i), {31'h0, bsy[i]},
                {31'h0, rst_n[i] && have[i] && edge_n <= rdy_edge[i]});
            if (rd_known[i])
                chk($sformatf("cyc%0d_rdata%0d", edge_n, i), rdata[i], exp_rd[i]);
        end
    end

    task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd);
        bit seen;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rdy[i]) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout inst%0d addr %h: no ready within %0d edges", i, a, lat);
        end
        rd = rdata[i];
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    int          lat, edges, pulses, first_at, second_at;
    logic [31:0] rd;

    initial begin
        rst_n = 2'b00; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 2'b11;

        // Preload through the write port.
        txn(0, 1, 32'h14, 32'h55AA55AA, 4'hF, lat, rd);
        txn(0, 1, 32'h20, 32'hDEADBEEF, 4'hF, lat, rd);
        txn(0, 1, 32'h24, 32'h99887766, 4'hF, lat, rd);
        txn(0, 1, 32'h0C, 32'h11223344, 4'hF, lat, rd);
        txn(0, 1, 32'h10, 32'h01020304, 4'hF, lat, rd);

        // Reset holds outputs low and preserves memory.
        @(negedge clk); rst_n[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'h0, rdy[0]}, 32'h0);
        chk("reset_busy", {31'h0, bsy[0]}, 32'h0);
        chk("reset_rdata", rdata[0], 32'h0);
        @(negedge clk); rst_n[0] = 1'b1;
        txn(0, 0, 32'h14, 32'h0, 4'h0, lat, rd);
        chk("preload_survives_reset", rd, 32'h55AA55AA);

        // Default read latency.
        txn(0, 0, 32'h20, 32'h0, 4'h0, lat, rd);
        chk("read_latency", lat, 4);
        chk("read_data_w8", rd, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("busy_low_after_read", {31'h0, bsy[0]}, 32'h0);

        // Byte-enable write and merge on read-back.
        txn(0, 1, 32'h0C, 32'hAABBCCDD, 4'b0101, lat, rd);
        chk("write_latency", lat, 2);
        txn(0, 0, 32'h0C, 32'h0, 4'h0, lat, rd);
        chk("byte_merge", rd, 32'h11BB33DD);

        // Write with no bytes enabled still handshakes, leaves memory alone.
        txn(0, 1, 32'h0C, 32'h00000000, 4'h0, lat, rd);
        chk("be0_write_latency", lat, 2);
        txn(0, 0, 32'h0C, 32'h0, 4'h0, lat, rd);
        chk("be0_unchanged", rd, 32'h11BB33DD);

        // Request held during busy with a changing address.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20;
        edges = 0; pulses = 0; first_at = 0; second_at = 0;
        while (pulses < 2 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (rdy[0]) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = edges;
                    chk("busy_hold_first_data", rdata[0], 32'hDEADBEEF);
                end else begin
                    second_at = edges;
                    chk("busy_hold_second_data", rdata[0], 32'h99887766);
                end
            end
            @(negedge clk);
            addr[0] = 32'h24;
        end
        req[0] = 1'b0;
        chk("busy_hold_first_at", first_at, 4);
        chk("busy_hold_gap", second_at - first_at, 5);

        // Reset during the write wait: no commit, no ready.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
        @(posedge clk); #1;
        chk("midwrite_busy", {31'h0, bsy[0]}, 32'h1);
        @(negedge clk);
        rst_n[0] = 1'b0; req[0] = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (rdy[0]) pulses++;
        end
        @(negedge clk); rst_n[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdy[0]) pulses++;
        end
        chk("midwrite_no_ready", pulses, 0);
        chk("midwrite_idle_busy", {31'h0, bsy[0]}, 32'h0);
        txn(0, 0, 32'h10, 32'h0, 4'h0, lat, rd);
        chk("midwrite_word4_kept", rd, 32'h01020304);

        // Zero read wait and address wrap on the small instance.
        txn(1, 1, 32'h04, 32'hCAFEF00D, 4'hF, lat, rd);
        chk("small_write_latency", lat, 2);
        txn(1, 0, 32'h44, 32'h0, 4'h0, lat, rd);
        chk("zero_wait_latency", lat, 1);
        chk("wrap_data", rd, 32'hCAFEF00D);
        txn(1, 0, 32'h04, 32'h0, 4'h0, lat, rd);
        chk("direct_data", rd, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
